// File: rtl/fifo_pkg.sv
// Shared constants and types for the MCDF channel FIFO read/status controller.
package fifo_pkg;

    localparam int unsigned DEF_PTR_WIDE   = 3;
    localparam int unsigned DEF_DEPTH      = 2 ** DEF_PTR_WIDE;
    localparam int unsigned DEF_AFULL_LVL  = 6;
    localparam int unsigned DEF_AEMPTY_LVL = 2;

    typedef logic [DEF_PTR_WIDE:0] ptr_t;
    typedef logic [DEF_PTR_WIDE:0] cnt_t;

    // Encoding is {rd_acc, wr_acc} so the helper below is a plain cast.
    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_WR   = 2'b01,
        ACC_RD   = 2'b10,
        ACC_BOTH = 2'b11
    } acc_e;

    function automatic acc_e acc_kind(input logic wr_acc, input logic rd_acc);
        return acc_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer counter: W+1 bits, advances on en_i, wraps from 2**(W+1)-1 to 0.
module fifo_ptr_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W:0]   ptr_o
);

    logic [W:0] ptr_q;
    logic [W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + (W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_rd_flag_gen.sv
// Read-side pointer and status flag generator for the MCDF channel FIFO.
// Define FIFO_ERR_FLAG_EN to build the sticky overflow/underflow registers.
module fifo_rd_flag_gen
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_PTR_WIDE = DEF_PTR_WIDE,
    parameter int unsigned AFULL_LVL     = DEF_AFULL_LVL,
    parameter int unsigned AEMPTY_LVL    = DEF_AEMPTY_LVL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [FIFO_PTR_WIDE-1:0] rd_addr,
    output logic [FIFO_PTR_WIDE:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DEPTH = 2 ** FIFO_PTR_WIDE;

    typedef logic [FIFO_PTR_WIDE:0] lptr_t;
    typedef logic [FIFO_PTR_WIDE:0] lcnt_t;

    if (!((AEMPTY_LVL < AFULL_LVL) && (AFULL_LVL <= DEPTH))) begin : g_bad_levels
        $error("fifo_rd_flag_gen: need 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH");
    end

    lptr_t wr_ptr;
    lptr_t rd_ptr;

    lcnt_t count_q, count_d;
    logic  full_q, full_d;
    logic  empty_q, empty_d;
    logic  afull_q, afull_d;
    logic  aempty_q, aempty_d;

    logic  wr_acc;
    logic  rd_acc;
    acc_e  acc;

    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;
    assign acc    = acc_kind(wr_acc, rd_acc);

    fifo_ptr_cnt #(.W(FIFO_PTR_WIDE)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_cnt #(.W(FIFO_PTR_WIDE)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (rd_acc),
        .ptr_o (rd_ptr)
    );

    // Flags are derived from next-count so they move on the same edge as count.
    always_comb begin
        count_d = count_q;
        unique case (acc)
            ACC_WR:  count_d = count_q + lcnt_t'(1);
            ACC_RD:  count_d = count_q - lcnt_t'(1);
            default: count_d = count_q;
        endcase
        full_d   = (count_d == lcnt_t'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= lcnt_t'(AFULL_LVL));
        aempty_d = (count_d <= lcnt_t'(AEMPTY_LVL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full_q);
        unf_d = unf_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign rd_addr      = rd_ptr[FIFO_PTR_WIDE-1:0];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

    a_ptr_consistent: assert property (@(posedge clk) disable iff (rst)
        (full_q  == ((wr_ptr[FIFO_PTR_WIDE-1:0] == rd_ptr[FIFO_PTR_WIDE-1:0]) &&
                     (wr_ptr[FIFO_PTR_WIDE] != rd_ptr[FIFO_PTR_WIDE]))) &&
        (empty_q == (wr_ptr == rd_ptr)) &&
        (count_q == lcnt_t'(wr_ptr - rd_ptr)));

endmodule

// File: tb/tb_fifo_rd_flag_gen.sv
// Self-checking bench for fifo_rd_flag_gen against an occupancy-level model.
module tb_fifo_rd_flag_gen;

    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 2;
`ifdef FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_addr;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int errs = 0;
    int checks = 0;
    bit check_en = 1'b0;

    int m_cnt = 0;
    int m_rd  = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    fifo_rd_flag_gen #(
        .FIFO_PTR_WIDE (3),
        .AFULL_LVL     (AFULL),
        .AEMPTY_LVL    (AEMPTY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: occupancy is a bounded integer; rd_addr counts accepted reads mod DEPTH.
    always @(posedge clk) begin
        bit wa, ra;
        if (rst) begin
            m_cnt <= 0;
            m_rd  <= 0;
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else begin
            wa = wr_en && (m_cnt < DEPTH);
            ra = rd_en && (m_cnt > 0);
            m_cnt <= m_cnt + int'(wa) - int'(ra);
            if (ra) m_rd <= (m_rd + 1) % DEPTH;
            if (ERR_EN && wr_en && m_cnt == DEPTH) m_ovf <= 1'b1;
            if (ERR_EN && rd_en && m_cnt == 0)     m_unf <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("count",        int'(count),        m_cnt);
            check("rd_addr",      int'(rd_addr),      m_rd);
            check("full",         int'(full),         int'(m_cnt == DEPTH));
            check("empty",        int'(empty),        int'(m_cnt == 0));
            check("almost_full",  int'(almost_full),  int'(m_cnt >= AFULL));
            check("almost_empty", int'(almost_empty), int'(m_cnt <= AEMPTY));
            check("overflow",     int'(overflow),     int'(m_ovf));
            check("underflow",    int'(underflow),    int'(m_unf));
        end
    end

    task automatic step(input bit w, input bit r);
        wr_en = w;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0);
        step(0, 0);
        rst = 1'b0;
        check_en = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0);
        check("lit_reset_count", int'(count), 0);
        check("lit_reset_empty", int'(empty), 1);
        check("lit_reset_aempty", int'(almost_empty), 1);
        check("lit_reset_rdaddr", int'(rd_addr), 0);
        check("lit_reset_full", int'(full), 0);

        for (int i = 1; i <= 8; i++) begin
            step(1, 0);
            check("lit_fill_count", int'(count), i);
            check("lit_fill_afull", int'(almost_full), int'(i >= 6));
            check("lit_fill_full", int'(full), int'(i == 8));
        end
        step(1, 0);
        check("lit_overwrite_count", int'(count), 8);
        check("lit_overflow", int'(overflow), int'(ERR_EN));

        for (int i = 1; i <= 8; i++) begin
            step(0, 1);
            check("lit_drain_rdaddr", int'(rd_addr), i % 8);
            check("lit_drain_aempty", int'(almost_empty), int'(8 - i <= 2));
        end
        check("lit_drain_empty", int'(empty), 1);
        step(0, 1);
        check("lit_underflow", int'(underflow), int'(ERR_EN));
        check("lit_underread_rdaddr", int'(rd_addr), 0);

        for (int i = 0; i < 8; i++) step(1, 0);
        step(1, 1);
        check("lit_both_full_count", int'(count), 7);
        check("lit_both_full_full", int'(full), 0);
        check("lit_both_full_rdaddr", int'(rd_addr), 1);
        for (int i = 0; i < 7; i++) step(0, 1);
        step(1, 1);
        check("lit_both_empty_count", int'(count), 1);
        check("lit_both_empty_empty", int'(empty), 0);
        check("lit_both_empty_rdaddr", int'(rd_addr), 0);

        for (int i = 0; i < 3; i++) step(1, 0);
        for (int i = 0; i < 20; i++) step(1, 1);
        check("lit_stream_count", int'(count), 4);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;

        step(0, 0);
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0);
        check("lit_pre_rst_count", int'(count), 5);
        rst = 1'b1;
        step(1, 0);
        rst = 1'b0;
        check("lit_rst_count", int'(count), 0);
        check("lit_rst_rdaddr", int'(rd_addr), 0);
        check("lit_rst_empty", int'(empty), 1);
        check("lit_rst_ovf", int'(overflow), 0);
        step(0, 0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_flag_gen.md
Name: fifo_rd_flag_gen

Overview:
Read-side and status controller for the MCDF channel FIFO. It pairs with the write address generator.
- Tracks a shadow write pointer and the read pointer, and generates the registered read address.
- Derives occupancy count and full/empty/almost flags from the two pointers.
- Drives `full` back to the write side and `empty` to the downstream arbiter.

Parameters:
- FIFO_PTR_WIDE, 3: address width; DEPTH = 2**FIFO_PTR_WIDE (8 by default).
- AFULL_LVL, 6: almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2: almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request; same signal that drives the write address generator.
- rd_en  in  1  read request from the downstream consumer.
- rd_addr  out  FIFO_PTR_WIDE  read address into the FIFO storage.
- count  out  FIFO_PTR_WIDE+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- overflow  out  1  sticky: write attempted while full (macro-dependent).
- underflow  out  1  sticky: read attempted while empty (macro-dependent).

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: rd_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, internal pointers=0.
  - Reset asserted mid-operation drops all state on the next edge.
  - Any in-flight request in the reset cycle is discarded.
- Acceptance is evaluated on the registered flags of the current cycle:
  - wr_acc = wr_en && !full
  - rd_acc = rd_en && !empty
- Pointers are FIFO_PTR_WIDE+1 bits: the extra MSB is the wrap bit.
  - wr_ptr advances on wr_acc; rd_ptr advances on rd_acc.
  - Both wrap from 2*DEPTH-1 to 0.
  - rd_addr = low FIFO_PTR_WIDE bits of rd_ptr.
  - rd_addr is registered and valid the cycle after the rd_acc that advanced it.
- Count update, per cycle:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
  - count never leaves 0..DEPTH.
- All flags are registered and computed from next-count, so they change on the same edge as count. Latency from request to flag update is one cycle.
- Simultaneous wr_en and rd_en:
  - When full: read accepted, write rejected; next count = DEPTH-1, full deasserts.
  - When empty: write accepted, read rejected; next count = 1, empty deasserts.
  - Otherwise both are accepted and count is unchanged.
- Pointer consistency invariant: full iff pointers have equal low bits and different MSB; empty iff pointers are identical. Implementation asserts this against count.
- Parameter legality: 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH. Violation is a static assertion error.

Optional Feature:
- Macro: FIFO_ERR_FLAG_EN.
- Defined:
  - overflow sets on any cycle with wr_en && full.
  - underflow sets on any cycle with rd_en && empty.
  - Both are sticky until rst.
  - A rejected access never alters pointers or count.
- Undefined: overflow and underflow are tied to 0 and no error registers are synthesised. Ports remain present.

Decomposition:
- Package fifo_pkg holds:
  - FIFO_PTR_WIDE default
  - derived DEPTH
  - ptr_t (FIFO_PTR_WIDE+1 bits) and cnt_t typedefs
  - default AFULL_LVL/AEMPTY_LVL constants
- One sub-module, fifo_ptr_cnt: wrap-bit pointer counter with enable.
  - Instantiated twice, as shadow write pointer and read pointer.
  - Synchronous active-high reset.

Test Plan:
- Reset then idle 5 cycles → rd_addr=0, count=0, empty=1, almost_empty=1, all other flags 0.
- 8 consecutive writes, no reads:
  - count steps 1..8
  - almost_full rises on the edge where count becomes 6
  - full rises on the edge where count becomes 8
  - 9th write leaves count=8
  - overflow=1 with FIFO_ERR_FLAG_EN, 0 without.
- From full, 8 reads:
  - rd_addr steps 1..7 then wraps to 0
  - count returns to 0, empty=1, almost_empty reasserts at count=2
  - extra read sets underflow (macro on).
- Full with wr_en=rd_en=1 for one cycle → count=7, full=0, rd_addr+1. Empty with both high → count=1, empty=0, rd_addr unchanged.
- Continuous simultaneous wr/rd at count=4 for 20 cycles → count stays 4, rd_addr wraps 0→7→0 cleanly, pointer-consistency assertion never fires.
- rst pulsed at count=5 during active writes → next edge count=0, rd_addr=0, empty=1, sticky errors cleared.
